// File: rtl/register_bist_pkg.sv
// Shared types and constants for the register_bist engine.
//   state_t      : BIST sequencer states
//   LFSR_WIDTH   : width of the stimulus LFSR
//   LFSR_MASK    : Galois tap mask for x^32+x^22+x^2+x+1
//   DEFAULT_SEED : seed used when none is supplied
//   lfsr_next()  : one right-shift Galois step
package register_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    SETTLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned LFSR_WIDTH = 32;
  localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 32'h0000_0001;

  // Right-shift Galois step: feedback bit is the LSB, taps folded in by the mask.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] q,
                                                      input logic [LFSR_WIDTH-1:0] mask);
    return (q >> 1) ^ (q[0] ? mask : '0);
  endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Right-shift Galois LFSR with synchronous load and step enable.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : load seed (has priority over step)
//   seed     : value loaded on load
//   step     : advance one position
//   q        : current LFSR state
module galois_lfsr #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] MASK = WIDTH'(32'h8020_0003)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  // LFSR state; reset to a non-zero value so it can never sit in the lockup state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= WIDTH'(1);
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= (q >> 1) ^ (q[0] ? MASK : '0);
    end
  end

endmodule

// File: rtl/register_bist.sv
// Built-in self-test engine for an enabled register. Holds the register in
// reset, drives pseudo-random in/en every RUN cycle, runs a cycle-accurate
// reference model and counts mismatches against the register output.
// Optional feature macro: REGISTER_BIST_FIRST_FAIL_EN (first-mismatch capture).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   go              : start pulse (honoured in IDLE and DONE)
//   dut_rst/en/in   : stimulus to the register under test
//   dut_out         : register under test output
//   done, passed    : run finished / finished with zero mismatches
//   error_count     : saturating mismatch count
//   first_fail_*    : index, expected and actual value of first mismatch
module register_bist
  import register_bist_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_TESTS    = 10000,
  parameter int unsigned RESET_CYCLES = 5,
  parameter logic [31:0] SEED         = DEFAULT_SEED,
  parameter int unsigned ERR_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  output logic                 dut_rst,
  output logic                 dut_en,
  output logic [WIDTH-1:0]     dut_in,
  input  logic [WIDTH-1:0]     dut_out,
  output logic                 done,
  output logic                 passed,
  output logic [ERR_WIDTH-1:0] error_count,
  output logic [31:0]          first_fail_idx,
  output logic [WIDTH-1:0]     first_fail_exp,
  output logic [WIDTH-1:0]     first_fail_act
);

  localparam logic [LFSR_WIDTH-1:0] SEED_EFF = (SEED == '0) ? LFSR_WIDTH'(1) : SEED;
  localparam logic [31:0] LAST_RESET = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] LAST_RUN   = 32'(NUM_TESTS - 1);
  localparam logic [31:0] DRAIN_IDX  = 32'(NUM_TESTS + 1);

  state_t                state, state_d;
  logic [31:0]           cnt, cnt_d;
  logic [ERR_WIDTH-1:0]  err_d;
  logic [WIDTH-1:0]      expected;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_ahead;
  logic                  start, lfsr_step, mismatch;
  logic                  dut_rst_d, dut_en_d, done_d, passed_d;
  logic [WIDTH-1:0]      dut_in_d;
  logic                  unused_lfsr_bits;

  assign unused_lfsr_bits = ^lfsr_ahead;

  galois_lfsr #(
    .WIDTH(LFSR_WIDTH),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .load(start),
    .seed(SEED_EFF),
    .step(lfsr_step),
    .q   (lfsr_q)
  );

  // Next-state, counters, comparator and next output values.
  // Outputs are registered from state_d, so the LFSR value for the coming
  // cycle (lfsr_ahead) is looked up here rather than taken from lfsr_q.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    err_d      = error_count;
    start      = 1'b0;
    lfsr_step  = 1'b0;
    lfsr_ahead = lfsr_q;
    mismatch   = 1'b0;
    dut_rst_d  = 1'b0;
    dut_en_d   = 1'b0;
    dut_in_d   = '0;
    done_d     = 1'b0;
    passed_d   = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (go) begin
          state_d = RESET;
          cnt_d   = '0;
          err_d   = '0;
          start   = 1'b1;
        end
      end
      RESET: begin
        if (cnt == LAST_RESET) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      SETTLE: begin
        state_d  = RUN;
        mismatch = (dut_out != expected);
      end
      RUN: begin
        lfsr_step  = 1'b1;
        lfsr_ahead = lfsr_next(lfsr_q, LFSR_MASK);
        mismatch   = (dut_out != expected);
        if (cnt == LAST_RUN) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      DRAIN: begin
        state_d  = DONE;
        mismatch = (dut_out != expected);
      end
      default: state_d = IDLE;
    endcase

    if (mismatch && (error_count != '1)) begin
      err_d = error_count + ERR_WIDTH'(1);
    end

    dut_rst_d = (state_d == IDLE) || (state_d == RESET);
    if (state_d == RUN) begin
      dut_en_d = lfsr_ahead[LFSR_WIDTH-1];
      dut_in_d = lfsr_ahead[WIDTH-1:0];
    end
    done_d   = (state_d == DONE);
    passed_d = done_d && (err_d == '0);
  end

  // State, counters, registered outputs and the reference model.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      error_count <= '0;
      expected    <= '0;
      dut_rst     <= 1'b1;
      dut_en      <= 1'b0;
      dut_in      <= '0;
      done        <= 1'b0;
      passed      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      error_count <= err_d;
      if (dut_rst) begin
        expected <= '0;
      end else if (dut_en) begin
        expected <= dut_in;
      end
      dut_rst <= dut_rst_d;
      dut_en  <= dut_en_d;
      dut_in  <= dut_in_d;
      done    <= done_d;
      passed  <= passed_d;
    end
  end

`ifdef REGISTER_BIST_FIRST_FAIL_EN
  logic        ff_valid;
  logic [31:0] cmp_idx;

  // Compare index: 0 in SETTLE, 1..NUM_TESTS in RUN, NUM_TESTS+1 in DRAIN.
  always_comb begin
    cmp_idx = DRAIN_IDX;
    if (state == SETTLE) begin
      cmp_idx = '0;
    end else if (state == RUN) begin
      cmp_idx = cnt + 32'd1;
    end
  end

  // Capture the first mismatch of a run; later mismatches leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_valid       <= 1'b0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_act <= '0;
    end else if (start) begin
      ff_valid       <= 1'b0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_act <= '0;
    end else if (mismatch && !ff_valid) begin
      ff_valid       <= 1'b1;
      first_fail_idx <= cmp_idx;
      first_fail_exp <= expected;
      first_fail_act <= dut_out;
    end
  end
`else
  assign first_fail_idx = '0;
  assign first_fail_exp = '0;
  assign first_fail_act = '0;
`endif

endmodule

// File: tb/tb_register_bist.sv
// Directed bench for register_bist: a behavioural register with selectable
// faults sits on the main instance; a second instance (ERR_WIDTH=2) always
// sees 8'hFF to exercise counter saturation.
module tb_register_bist;

  localparam int unsigned W = 8;
  localparam int unsigned N = 16;
  localparam int unsigned R = 5;
  localparam logic [31:0] MASK = 32'h8020_0003;

  logic         clk, rst, go;
  logic         dut_rst, dut_en, done, passed;
  logic [W-1:0] dut_in, dut_out;
  logic [15:0]  error_count;
  logic [31:0]  ff_idx;
  logic [W-1:0] ff_exp, ff_act;

  logic         s_rst, s_en, s_done, s_passed;
  logic [W-1:0] s_in, s_ff_exp, s_ff_act;
  logic [1:0]   s_err;
  logic [31:0]  s_ff_idx;

  int           mode;  // 0 good, 1 bit0 stuck at 1, 2 ignores en
  logic [W-1:0] r;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] stim_in [N];
  logic         stim_en [N];
  logic [W-1:0] hand_in [4];
  logic         hand_en [4];

  register_bist #(.WIDTH(W), .NUM_TESTS(N), .RESET_CYCLES(R), .SEED(32'h1), .ERR_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .go(go), .dut_rst(dut_rst), .dut_en(dut_en), .dut_in(dut_in),
    .dut_out(dut_out), .done(done), .passed(passed), .error_count(error_count),
    .first_fail_idx(ff_idx), .first_fail_exp(ff_exp), .first_fail_act(ff_act)
  );

  register_bist #(.WIDTH(W), .NUM_TESTS(N), .RESET_CYCLES(R), .SEED(32'h1), .ERR_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .go(go), .dut_rst(s_rst), .dut_en(s_en), .dut_in(s_in),
    .dut_out(8'hFF), .done(s_done), .passed(s_passed), .error_count(s_err),
    .first_fail_idx(s_ff_idx), .first_fail_exp(s_ff_exp), .first_fail_act(s_ff_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register under test, with injectable faults.
  always @(posedge clk) begin
    if (dut_rst) r <= '0;
    else if (dut_en || mode == 2) r <= dut_in;
  end
  assign dut_out = (mode == 1) ? (r | 8'h01) : r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected mismatch count and first failure for a fault mode. Compare
  // points are: result of reset, result of SETTLE, results of RUN 1..N.
  task automatic model_run(input int m, output int errs, output logic [31:0] fidx,
                           output logic [W-1:0] fexp, output logic [W-1:0] fact);
    logic [W-1:0] e, q, o;
    bit found;
    e = '0; q = '0; errs = 0; fidx = '0; fexp = '0; fact = '0; found = 0;
    for (int i = 0; i < int'(N) + 2; i++) begin
      if (i >= 2) begin
        if (stim_en[i-2]) e = stim_in[i-2];
        if (stim_en[i-2] || m == 2) q = stim_in[i-2];
      end
      o = (m == 1) ? (q | 8'h01) : q;
      if (o !== e) begin
        errs++;
        if (!found) begin
          found = 1; fidx = 32'(i); fexp = e; fact = o;
        end
      end
    end
  endtask

  // One BIST run. inj: 0 none, 1 go pulse mid-RUN, 2 rst pulse mid-RUN (abort).
  task automatic do_run(input int m, input int inj, input bit hand);
    int errs, e;
    logic [31:0] fidx;
    logic [W-1:0] fexp, fact;
    mode = m;
    model_run(m, errs, fidx, fexp, fact);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_edge_done", 32'(done), 32'd0);
    check("go_edge_passed", 32'(passed), 32'd0);
    check("go_edge_err_clr", 32'(error_count), 32'd0);
    e = 0;
    while (done !== 1'b1 && e < 100) begin
      tick();
      e++;
      if (e == int'(R) - 1) check("reset_dut_rst", 32'(dut_rst), 32'd1);
      if (e == int'(R)) begin
        check("settle_dut_rst", 32'(dut_rst), 32'd0);
        check("settle_dut_en", 32'(dut_en), 32'd0);
      end
      if (e >= int'(R) + 1 && e <= int'(R + N)) begin
        check("run_dut_in", 32'(dut_in), 32'(stim_in[e-int'(R)-1]));
        check("run_dut_en", 32'(dut_en), 32'(stim_en[e-int'(R)-1]));
        if (hand && e - int'(R) - 1 < 4) begin
          check("hand_dut_in", 32'(dut_in), 32'(hand_in[e-int'(R)-1]));
          check("hand_dut_en", 32'(dut_en), 32'(hand_en[e-int'(R)-1]));
        end
      end
      if (e == 10 && inj == 1) go = 1'b1;
      if (e == 11 && inj == 1) go = 1'b0;
      if (e == 10 && inj == 2) begin
        rst = 1'b1;
        #1;
        check("abort_dut_rst", 32'(dut_rst), 32'd1);
        check("abort_dut_en", 32'(dut_en), 32'd0);
        check("abort_dut_in", 32'(dut_in), 32'd0);
        check("abort_err", 32'(error_count), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_idle_dut_rst", 32'(dut_rst), 32'd1);
        check("abort_idle_done", 32'(done), 32'd0);
        check("abort_idle_passed", 32'(passed), 32'd0);
        return;
      end
    end
    check("latency", 32'(e), 32'(R + N + 2));
    check("done", 32'(done), 32'd1);
    check("passed", 32'(passed), 32'(errs == 0));
    check("error_count", 32'(error_count), 32'(errs));
`ifdef REGISTER_BIST_FIRST_FAIL_EN
    check("ff_idx", ff_idx, fidx);
    check("ff_exp", 32'(ff_exp), 32'(fexp));
    check("ff_act", 32'(ff_act), 32'(fact));
`else
    check("ff_idx_tied", ff_idx, 32'd0);
    check("ff_act_tied", 32'(ff_act), 32'd0);
`endif
    check("sat_done", 32'(s_done), 32'd1);
    check("sat_err", 32'(s_err), 32'd3);
    check("sat_passed", 32'(s_passed), 32'd0);
  endtask

  initial begin
    logic [31:0] q;
    q = 32'h1;
    for (int i = 0; i < int'(N); i++) begin
      stim_in[i] = q[W-1:0];
      stim_en[i] = q[31];
      q = (q >> 1) ^ (q[0] ? MASK : 32'h0);
    end
    // Seed 1: 0x00000001, 0x80200003, 0xC0300002, 0x60180001
    hand_in = '{8'h01, 8'h03, 8'h02, 8'h01};
    hand_en = '{1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; go = 1'b0; mode = 0;
    repeat (2) tick();
    check("rst_dut_rst", 32'(dut_rst), 32'd1);
    check("rst_dut_en", 32'(dut_en), 32'd0);
    check("rst_dut_in", 32'(dut_in), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_passed", 32'(passed), 32'd0);
    check("rst_err", 32'(error_count), 32'd0);
    check("rst_ff_idx", ff_idx, 32'd0);
    check("rst_ff_exp", 32'(ff_exp), 32'd0);
    check("rst_ff_act", 32'(ff_act), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_dut_rst", 32'(dut_rst), 32'd1);

    do_run(0, 1, 1'b1);  // good register, stray go during RUN
    do_run(0, 0, 1'b1);  // restart from DONE, same stimulus
    do_run(1, 0, 1'b0);  // bit 0 stuck at 1
`ifdef REGISTER_BIST_FIRST_FAIL_EN
    check("stuck_ff_act0", 32'(ff_act[0]), 32'd1);
    check("stuck_ff_exp0", 32'(ff_exp[0]), 32'd0);
`endif
    do_run(2, 0, 1'b0);  // ignores en
    do_run(1, 2, 1'b0);  // abort mid-RUN with errors already counted
    do_run(0, 0, 1'b1);  // fresh run after abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_bist.md
# register_bist

Synthesizable built-in self-test engine for the enabled `register` block; it drives the other end of the register's interface. It holds the register in reset, then drives pseudo-random `in`/`en` stimulus every cycle. It runs a cycle-accurate reference model and counts mismatches against the register's `out`. It sits beside a `register` instance in hardware and gives on-silicon or FPGA pass/fail without a simulator.

## Interface
- `WIDTH`, 8: data width of the register under test; legal range 1..31.
- `NUM_TESTS`, 10000: number of random stimulus cycles.
- `RESET_CYCLES`, 5: cycles `dut_rst` is held after `go`; must be ≥1.
- `SEED`, 32'h1: LFSR seed; a value of 0 is replaced by 1.
- `ERR_WIDTH`, 16: width of the error counter.

Ports:
- `clk`  in  1: the one clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `go`  in  1: start pulse; sampled in IDLE and DONE only.
- `dut_rst`  out  1: reset to the register.
- `dut_en`  out  1: enable to the register.
- `dut_in`  out  WIDTH: data to the register.
- `dut_out`  in  WIDTH: output of the register.
- `done`  out  1: run finished; sticky until the next `go`.
- `passed`  out  1: `done` && `error_count`==0.
- `error_count`  out  ERR_WIDTH: mismatches, saturating at all-ones.
- `first_fail_idx`  out  32: compare index of the first mismatch.
- `first_fail_exp`  out  WIDTH: expected value at the first mismatch.
- `first_fail_act`  out  WIDTH: actual value at the first mismatch.

## Operation
- FSM states and transitions:
  - IDLE → RESET on `go`.
  - RESET (RESET_CYCLES cycles) → SETTLE (1 cycle) → RUN (NUM_TESTS cycles) → DRAIN (1 cycle) → DONE.
  - DONE → RESET on `go`.
- `go` in RESET/SETTLE/RUN/DRAIN is ignored.
- Outputs by state:
  - `dut_rst`=1 in IDLE and RESET, else 0.
  - `dut_en`=0 and `dut_in`=0 outside RUN.
  - In RUN: `dut_in`=lfsr[WIDTH-1:0], `dut_en`=lfsr[31].
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003).
  - Loaded with SEED on entry to RESET.
  - Advances once per RUN cycle only.
  - Identical SEED yields an identical stimulus sequence.
- Reference model, updated every edge: `expected` <= `dut_rst` ? 0 : `dut_en` ? `dut_in` : `expected`.
- Compare window:
  - Compare happens in SETTLE, RUN and DRAIN (NUM_TESTS+2 compares).
  - A mismatch (`dut_out` != `expected`) increments `error_count` at that edge.
  - The counter saturates at 2^ERR_WIDTH-1.
- `error_count` clears on entry to RESET.
- Async `rst` at any time, including mid-RUN:
  - FSM goes to IDLE; all outputs go to reset values; `expected`=0.
  - No partial result is reported.

## Timing
- Reset values: `dut_rst`=1, `dut_en`=0, `dut_in`=0, `done`=0, `passed`=0, `error_count`=0, all `first_fail_*`=0.
- All outputs are registered or decoded from registered state; no combinational path exists from `dut_out` to any output.
- Latency from the edge sampling `go` to `done`=1 is RESET_CYCLES+NUM_TESTS+2 edges.
- `done` and `passed` rise in the same cycle.
- The compare index is 0 for SETTLE, 1..NUM_TESTS for RUN, and NUM_TESTS+1 for DRAIN.
- `go` in DONE drops `done`/`passed` on the next edge.

## Configuration
- Macro: `REGISTER_BIST_FIRST_FAIL_EN`.
- Defined:
  - On the first mismatch of a run, capture index, `expected` and `dut_out` into `first_fail_*`.
  - Later mismatches do not overwrite the captured values.
  - Captured values clear on entry to RESET.
- Undefined: `first_fail_*` ports remain and are tied to 0; no capture logic is synthesized.

## Structure
- `register_bist_pkg` holds:
  - `state_t` enum (IDLE, RESET, SETTLE, RUN, DRAIN, DONE);
  - `LFSR_WIDTH`=32;
  - `LFSR_MASK`;
  - `DEFAULT_SEED`.
- Sub-module `galois_lfsr`: parameters WIDTH, MASK; ports `clk`, `rst`, `load`, `seed`, `step`, `q`.
- The FSM, counters, reference model and comparator live in `register_bist`.

## Test plan
- Correct `register`, WIDTH=8, NUM_TESTS=16, RESET_CYCLES=5, one `go` pulse → `done` rises exactly 23 edges later, `passed`=1, `error_count`=0.
- Register with bit 0 stuck at 1, NUM_TESTS=64 → `passed`=0, `error_count`>0. With the macro defined, `first_fail_act[0]`=1 and `first_fail_exp[0]`=0.
- Register that ignores `en` (always loads), NUM_TESTS=64 → `error_count` equals the bench's own count of RUN cycles with `en`=0 where `in` differed from the held value.
- ERR_WIDTH=2, DUT output forced to 8'hFF → `error_count`=3 (saturated), `passed`=0.
- `rst` asserted for 1 cycle mid-RUN → next cycle IDLE, `dut_rst`=1, `error_count`=0, `done`=0. A later `go` runs to `passed`=1 with the same stimulus as SEED dictates.
- `go` pulsed during RUN → no effect on latency. `go` in DONE → `done` clears next edge, the run repeats, and the `dut_in` sequence is identical to the first run.
